// File: rtl/fpnew_fma_out_pipe.sv
// fpnew_fma_out_pipe: elastic output stage behind fpnew_fma.
// The FMA result, an operation tag and NaN/Inf flags travel through
// NumPipeRegs register stages. Each stage is a valid/ready slot.
// Optional feature macro: FPNEW_OUT_PIPE_CANON_NAN_EN. When it is defined,
// every NaN is replaced by the canonical quiet NaN before stage 0.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. Valid never depends on ready. A producer must keep
// its valid beat stable until that beat is taken. A flush cancels the beat in
// its cycle, both the input beat and the output beat.

package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction
endpackage

module fpnew_fma_out_pipe #(
  parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::fp_format_e'(0),
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned TagWidth    = 4,
  localparam int unsigned EXP_BITS   = fpnew_pkg::exp_bits(FpFormat),
  localparam int unsigned MAN_BITS   = fpnew_pkg::man_bits(FpFormat),
  localparam int unsigned WIDTH      = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    in_result_i,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WIDTH-1:0]    out_result_o,
  output logic [TagWidth-1:0] out_tag_o,
  output logic                out_is_nan_o,
  output logic                out_is_inf_o,
  output logic                busy_o
);

  localparam int LAST = int'(NumPipeRegs) - 1;
  localparam logic [WIDTH-1:0] CANON_NAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

  // A value outside 1..4 for NumPipeRegs stops elaboration.
  if (NumPipeRegs < 1 || NumPipeRegs > 4) begin : g_bad_depth
    $error("fpnew_fma_out_pipe: NumPipeRegs must be in 1..4");
  end

  // Per-stage state
  logic [NumPipeRegs-1:0] r_valid;
  logic [WIDTH-1:0]       r_data [NumPipeRegs];
  logic [TagWidth-1:0]    r_tag  [NumPipeRegs];
  logic [NumPipeRegs-1:0] r_nan;
  logic [NumPipeRegs-1:0] r_inf;

  logic [NumPipeRegs:0]   w_ready;
  logic                   w_accept;
  logic [EXP_BITS-1:0]    w_exp;
  logic [MAN_BITS-1:0]    w_man;
  logic                   w_is_nan;
  logic                   w_is_inf;
  logic [WIDTH-1:0]       w_in_data;

  // Classify the incoming result. Only a NaN can be rewritten, so the flags
  // stay valid for the canonical value as well.
  assign w_exp    = in_result_i[MAN_BITS +: EXP_BITS];
  assign w_man    = in_result_i[MAN_BITS-1:0];
  assign w_is_nan = (&w_exp) & (|w_man);
  assign w_is_inf = (&w_exp) & ~(|w_man);

`ifdef FPNEW_OUT_PIPE_CANON_NAN_EN
  assign w_in_data = w_is_nan ? CANON_NAN : in_result_i;
`else
  assign w_in_data = in_result_i;
`endif

  // Ready chain from out_ready_i back to stage 0. An empty stage is always
  // ready, so a bubble closes up in the same cycle.
  always_comb begin
    w_ready = '0;
    w_ready[NumPipeRegs] = out_ready_i;
    for (int k = LAST; k >= 0; k--) begin
      w_ready[k] = ~r_valid[k] | w_ready[k+1];
    end
  end

  assign in_ready_o = w_ready[0] & ~flush_i;
  assign w_accept   = in_valid_i & in_ready_o;

  // Valid bits: a flush clears them, and otherwise each stage that is ready takes its upstream valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      if (w_ready[0]) r_valid[0] <= in_valid_i;
      for (int k = 1; k < int'(NumPipeRegs); k++) begin
        if (w_ready[k]) r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Payload registers: copied only with a valid beat, held while the stage is empty or stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NumPipeRegs); k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
      r_nan <= '0;
      r_inf <= '0;
    end else begin
      if (w_accept) begin
        r_data[0] <= w_in_data;
        r_tag[0]  <= in_tag_i;
        r_nan[0]  <= w_is_nan;
        r_inf[0]  <= w_is_inf;
      end
      for (int k = 1; k < int'(NumPipeRegs); k++) begin
        if (w_ready[k] && r_valid[k-1]) begin
          r_data[k] <= r_data[k-1];
          r_tag[k]  <= r_tag[k-1];
          r_nan[k]  <= r_nan[k-1];
          r_inf[k]  <= r_inf[k-1];
        end
      end
    end
  end

  assign out_valid_o  = r_valid[LAST];
  assign out_result_o = r_data[LAST];
  assign out_tag_o    = r_tag[LAST];
  assign out_is_nan_o = r_nan[LAST];
  assign out_is_inf_o = r_inf[LAST];
  assign busy_o       = |r_valid;

endmodule

// File: tb/tb_fpnew_fma_out_pipe.sv
// Testbench for fpnew_fma_out_pipe.
// Instance a uses FP32 with 2 stages. Instance b uses FP64 with 4 stages.
// The expected NaN result depends on FPNEW_OUT_PIPE_CANON_NAN_EN.
module tb_fpnew_fma_out_pipe;

  localparam int WA = 32;
  localparam int WB = 64;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: FP32 with 2 stages
  logic          a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0;
  logic [WA-1:0] a_in_result = '0, a_out_result;
  logic [TW-1:0] a_in_tag = '0, a_out_tag;
  logic          a_out_valid, a_out_ready = 1'b0, a_nan, a_inf, a_busy;

  fpnew_fma_out_pipe #(
    .FpFormat(fpnew_pkg::FP32), .NumPipeRegs(2), .TagWidth(TW)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_result_i(a_in_result), .in_tag_i(a_in_tag), .flush_i(a_flush),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_result_o(a_out_result), .out_tag_o(a_out_tag),
    .out_is_nan_o(a_nan), .out_is_inf_o(a_inf), .busy_o(a_busy)
  );

  // Instance b: FP64 with 4 stages
  logic          b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0;
  logic [WB-1:0] b_in_result = '0, b_out_result;
  logic [TW-1:0] b_in_tag = '0, b_out_tag;
  logic          b_out_valid, b_out_ready = 1'b0, b_nan, b_inf, b_busy;

  fpnew_fma_out_pipe #(
    .FpFormat(fpnew_pkg::FP64), .NumPipeRegs(4), .TagWidth(TW)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_result_i(b_in_result), .in_tag_i(b_in_tag), .flush_i(b_flush),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_result_o(b_out_result), .out_tag_o(b_out_tag),
    .out_is_nan_o(b_nan), .out_is_inf_o(b_inf), .busy_o(b_busy)
  );

  // Scoreboard for instance b: {result, tag, nan, inf} and the accept cycle
  logic [WB+TW+1:0] exp_q[$];
  int               acc_q[$];

  // Expected FP32 output word {valid, result, tag, nan, inf}
  function automatic logic [WA+TW+2:0] model_a(logic [WA-1:0] d, logic [TW-1:0] t);
    logic nan, inf;
    nan = (d[30:23] == 8'hFF) && (d[22:0] != 0);
    inf = (d[30:23] == 8'hFF) && (d[22:0] == 0);
`ifdef FPNEW_OUT_PIPE_CANON_NAN_EN
    if (nan) d = 32'h7FC00000;
`endif
    return {1'b1, d, t, nan, inf};
  endfunction

  // Expected FP64 scoreboard entry {result, tag, nan, inf}
  function automatic logic [WB+TW+1:0] model_b(logic [WB-1:0] d, logic [TW-1:0] t);
    logic nan, inf;
    nan = (d[62:52] == 11'h7FF) && (d[51:0] != 0);
    inf = (d[62:52] == 11'h7FF) && (d[51:0] == 0);
`ifdef FPNEW_OUT_PIPE_CANON_NAN_EN
    if (nan) d = 64'h7FF8000000000000;
`endif
    return {d, t, nan, inf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_result = 32'h3F800000; a_in_tag = 4'd9; a_out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if ({a_out_valid, a_out_result, a_out_tag, a_nan, a_inf, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b r=%h t=%h n=%0b i=%0b busy=%0b want all 0",
               a_out_valid, a_out_result, a_out_tag, a_nan, a_inf, a_busy);
    end
    checks++;
    if ({b_out_valid, b_out_result, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b got v=%0b r=%h busy=%0b want 0", b_out_valid, b_out_result, b_busy);
    end
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", a_in_ready);
    end
    step();
    checks++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_accept got v=%0b busy=%0b want 0 0", a_out_valid, a_busy);
    end
  endtask

  task automatic test_latency();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_result = 32'h7F800000; a_in_tag = 4'd3;
    step();
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got v=%0b want 0", a_out_valid);
    end
    step();
    checks++;
    if ({a_out_valid, a_out_result, a_out_tag, a_nan, a_inf} !== {1'b1, 32'h7F800000, 4'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL latency_inf got v=%0b r=%h t=%h n=%0b i=%0b want 1 7f800000 3 0 1",
               a_out_valid, a_out_result, a_out_tag, a_nan, a_inf);
    end
    step();
    checks++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL latency_retire got v=%0b busy=%0b want 0 0", a_out_valid, a_busy);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_result = 32'h3F800000; a_in_tag = 4'd0;
    step();
    a_in_result = 32'h40000000; a_in_tag = 4'd1;
    step();
    a_in_result = 32'h40400000; a_in_tag = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({a_in_ready, a_out_valid, a_out_result, a_out_tag} !== {1'b0, 1'b1, 32'h3F800000, 4'd0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rdy=%0b v=%0b r=%h t=%h want 0 1 3f800000 0",
                 i, a_in_ready, a_out_valid, a_out_result, a_out_tag);
      end
      step();
    end
    // Full pipe with both ends ready: retire, shift and accept together.
    a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_full_accept got rdy=%0b want 1", a_in_ready);
    end
    step();
    a_in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_out_result, a_out_tag} !== {1'b1, 32'h40000000, 4'd1}) begin
      errors++;
      $display("FAIL bp_second got v=%0b r=%h t=%h want 1 40000000 1", a_out_valid, a_out_result, a_out_tag);
    end
    step();
    checks++;
    if ({a_out_valid, a_out_result, a_out_tag} !== {1'b1, 32'h40400000, 4'd2}) begin
      errors++;
      $display("FAIL bp_third got v=%0b r=%h t=%h want 1 40400000 2", a_out_valid, a_out_result, a_out_tag);
    end
    step();
    checks++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_drained got v=%0b busy=%0b want 0 0", a_out_valid, a_busy);
    end
  endtask

  task automatic test_nan();
    logic [WA-1:0] exp_r;
`ifdef FPNEW_OUT_PIPE_CANON_NAN_EN
    exp_r = 32'h7FC00000;
`else
    exp_r = 32'hFFFFFFFF;
`endif
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_result = 32'hFFFFFFFF; a_in_tag = 4'd5;
    step();
    a_in_valid = 1'b0;
    step();
    checks++;
    if ({a_out_valid, a_out_result, a_out_tag, a_nan, a_inf} !== {1'b1, exp_r, 4'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL nan_canon got v=%0b r=%h t=%h n=%0b i=%0b want 1 %h 5 1 0",
               a_out_valid, a_out_result, a_out_tag, a_nan, a_inf, exp_r);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [WA-1:0] vals [4];
    logic [WA+TW+2:0] want;
    vals[0] = 32'h00000000; vals[1] = 32'h80000000;
    vals[2] = 32'h7F7FFFFF; vals[3] = 32'h7F800001;
    a_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_in_valid  = (i < 4);
      a_in_result = vals[i % 4];
      a_in_tag    = 4'(i + 8);
      #1;
      if (i < 4) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready beat %0d got %0b want 1", i, a_in_ready);
        end
      end
      if (i >= 2 && i < 6) begin
        want = model_a(vals[i-2], 4'(i + 6));
        checks++;
        if ({a_out_valid, a_out_result, a_out_tag, a_nan, a_inf} !== want) begin
          errors++;
          $display("FAIL b2b_out beat %0d got %h want %h", i - 2,
                   {a_out_valid, a_out_result, a_out_tag, a_nan, a_inf}, want);
        end
      end
      if (i == 6) begin
        checks++;
        if ({a_out_valid, a_busy} !== 2'b00) begin
          errors++;
          $display("FAIL b2b_end got v=%0b busy=%0b want 0 0", a_out_valid, a_busy);
        end
      end
      step();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_result = 32'h3F800000; a_in_tag = 4'd5;
    step();
    a_in_result = 32'h40000000; a_in_tag = 4'd6;
    step();
    // The flush cycle also presents an output handshake, and the flush wins.
    a_in_result = 32'h40400000; a_in_tag = 4'd7;
    a_flush = 1'b1; a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready got %0b want 0", a_in_ready);
    end
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_clear got v=%0b busy=%0b want 0 0", a_out_valid, a_busy);
    end
    step();
    checks++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_not_accepted got v=%0b busy=%0b want 0 0", a_out_valid, a_busy);
    end
  endtask

  // One FP64 cycle: drive the inputs, then score both handshakes before the edge.
  task automatic b_cycle(input logic vld, input logic rdy, input int idx, input logic chk_lat);
    logic [WB+TW+1:0] got, want;
    int acc;
    b_in_valid  = vld;
    b_out_ready = rdy;
    if (idx % 9 == 3)
      b_in_result = {1'($urandom_range(0, 1)), 11'h7FF, 52'h0};
    else if (idx % 9 == 6)
      b_in_result = {1'($urandom_range(0, 1)), 11'h7FF, 20'($urandom), 32'($urandom) | 32'h1};
    else
      b_in_result = {32'($urandom), 32'($urandom)};
    b_in_tag = 4'($urandom_range(0, 15));
    #1;
    if (b_out_valid && b_out_ready) begin
      got = {b_out_result, b_out_tag, b_nan, b_inf};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fp64_unexpected got %h with empty queue", got);
      end else begin
        want = exp_q.pop_front();
        acc  = acc_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL fp64_data got %h want %h", got, want);
        end
        if (chk_lat) begin
          checks++;
          if (cyc - acc != 4) begin
            errors++;
            $display("FAIL fp64_latency got %0d want 4", cyc - acc);
          end
        end
      end
    end
    if (b_in_valid && b_in_ready) begin
      exp_q.push_back(model_b(b_in_result, b_in_tag));
      acc_q.push_back(cyc);
    end
    step();
  endtask

  task automatic b_drain(input string tag);
    for (int i = 0; i < 20 && (b_busy || exp_q.size() != 0); i++) b_cycle(1'b0, 1'b1, 1, 1'b0);
    checks++;
    if (b_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s got busy=%0b left=%0d want 0 0", tag, b_busy, exp_q.size());
    end
  endtask

  task automatic test_fp64_stream();
    for (int i = 0; i < 150; i++) b_cycle(1'b1, ($urandom_range(0, 3) != 0), i, 1'b0);
    b_drain("fp64_drain_random");
    for (int i = 0; i < 30; i++) b_cycle(1'b1, 1'b1, i, 1'b1);
    b_drain("fp64_drain_full");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_nan();
    test_back_to_back();
    test_flush();
    test_fp64_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
